// File: rtl/vxe_fifo_wr_arb.sv
// Round-robin arbiter giving NREQ requesters bursts of up to BURST_LEN writes into one shared FIFO.
// One IDLE decision cycle per grant; fifo_full stalls the granted requester in place (req_ready low).
module vxe_fifo_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic [2:0]                 fifo_src,
  output logic                       busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   gnt_d;
  logic            pick_vld;
  logic [IW-1:0]   idx_c;
  int              sum_c;

  // Walk from farthest to nearest so the first valid index after last_q wins.
  always_comb begin
    gnt_d    = '0;
    pick_vld = 1'b0;
    idx_c    = '0;
    sum_c    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      sum_c = int'(last_q) + k;
      if (sum_c >= NREQ) sum_c = sum_c - NREQ;
      idx_c = IW'(sum_c);
      if (req_valid[idx_c]) begin
        gnt_d    = idx_c;
        pick_vld = 1'b1;
      end
    end
  end

  assign busy = (state_q == GRANT);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[gnt_q] = !fifo_full;
  end

  assign fifo_wr   = req_valid[gnt_q] & req_ready[gnt_q];
  assign fifo_data = req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_src  = 3'(gnt_q);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ-1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q   <= gnt_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[gnt_q]) begin
            last_q  <= gnt_q;
            state_q <= IDLE;
          end else if (fifo_wr) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(BURST_LEN-1)) begin
              last_q  <= gnt_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vxe_fifo_wr_arb.sv
// Directed and randomised checks of vxe_fifo_wr_arb with NREQ=4, BURST_LEN=4.
module tb_vxe_fifo_wr_arb;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            srst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_data;
  logic [2:0]      fifo_src;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int seq[N];

  vxe_fifo_wr_arb #(.DATA_WIDTH(DW), .NREQ(N), .BURST_LEN(BL)) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_src(fifo_src), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i, input int s);
    logic [31:0] r;
    r = {4'hA, 4'(i), 24'(s)};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word(i, seq[i]);
  endtask

  task automatic accept();
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
  endtask

  task automatic do_reset();
    srst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data();
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data();
    srst = 1'b1; req_valid = '1; fifo_full = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy c%0d: got %b want 0", c, busy); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready c%0d: got %b want 0000", c, req_ready); end
      checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL rst_wr c%0d: got %b want 0", c, fifo_wr); end
      checks++; if (fifo_src !== 3'd0) begin errors++; $display("FAIL rst_src c%0d: got %0d want 0", c, fifo_src); end
      checks++; if (fifo_data !== word(0, 0)) begin errors++; $display("FAIL rst_data c%0d: got %h want %h", c, fifo_data, word(0, 0)); end
      tick();
    end
    srst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_single_req();
    logic [6:0] exp_wr;
    int w, nwr;
    exp_wr = 7'b1011110;
    w = 0; nwr = 0;
    do_reset();
    req_data[2*DW +: DW] = 32'hBEEF_0001;
    req_valid = 4'b0100;
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++; if (fifo_wr !== exp_wr[c]) begin errors++; $display("FAIL single_wr c%0d: got %b want %b", c, fifo_wr, exp_wr[c]); end
      if (exp_wr[c]) begin
        checks++;
        if (fifo_data !== 32'hBEEF_0001 + nwr || fifo_src !== 3'd2) begin
          errors++; $display("FAIL single_dat c%0d: got %h/src%0d want %h/src2", c, fifo_data, fifo_src, 32'hBEEF_0001 + nwr);
        end
        nwr++;
      end
      if (req_valid[2] && req_ready[2]) w++;
      tick();
      req_data[2*DW +: DW] = 32'hBEEF_0001 + w;
      if (w == 5) req_valid = 4'b0000;
    end
    tick();
  endtask

  task automatic test_round_robin();
    int order[5];
    int ecnt[N];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) ecnt[i] = 0;
    do_reset();
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 5; c++) begin
        #1;
        if (c == 0) begin
          checks++;
          if (fifo_wr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_idle g%0d: got wr=%b busy=%b want 0/0", g, fifo_wr, busy);
          end
        end else begin
          checks++;
          if (fifo_wr !== 1'b1 || fifo_src !== 3'(order[g]) || fifo_data !== word(order[g], ecnt[order[g]])) begin
            errors++; $display("FAIL rr_write g%0d c%0d: got wr=%b src=%0d data=%h want 1/%0d/%h",
                               g, c, fifo_wr, fifo_src, fifo_data, order[g], word(order[g], ecnt[order[g]]));
          end
          ecnt[order[g]]++;
        end
        accept();
        tick();
        drive_data();
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_full_stall();
    logic [8:0] full_tab, exp_wr, exp_busy;
    logic [3:0] exp_rdy;
    int nwr;
    full_tab = 9'b000111000;
    exp_wr   = 9'b011000110;
    exp_busy = 9'b011111110;
    nwr = 0;
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      fifo_full = full_tab[c];
      #1;
      exp_rdy = (exp_busy[c] && !full_tab[c]) ? 4'b0010 : 4'b0000;
      checks++; if (fifo_wr !== exp_wr[c]) begin errors++; $display("FAIL stall_wr c%0d: got %b want %b", c, fifo_wr, exp_wr[c]); end
      checks++; if (busy !== exp_busy[c]) begin errors++; $display("FAIL stall_busy c%0d: got %b want %b", c, busy, exp_busy[c]); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL stall_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
      if (full_tab[c]) begin
        checks++; if (dut.cnt_q !== 4'd2) begin errors++; $display("FAIL stall_cnt c%0d: got %0d want 2", c, dut.cnt_q); end
      end
      if (exp_wr[c]) begin
        checks++;
        if (fifo_data !== word(1, nwr)) begin errors++; $display("FAIL stall_data c%0d: got %h want %h", c, fifo_data, word(1, nwr)); end
        nwr++;
      end
      accept();
      tick();
      drive_data();
    end
    fifo_full = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 4'b1000;
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got wr=%b busy=%b want 0/0", fifo_wr, busy); end
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_src !== 3'd3) begin errors++; $display("FAIL drop_w1: got wr=%b src=%0d want 1/3", fifo_wr, fifo_src); end
    accept();
    tick();
    drive_data();
    req_valid = 4'b0001;
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b1 || req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL drop_exit: got wr=%b busy=%b rdy=%b want 0/1/rdy0=0", fifo_wr, busy, req_ready);
    end
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle2: got wr=%b busy=%b want 0/0", fifo_wr, busy); end
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_src !== 3'd0) begin errors++; $display("FAIL drop_wrap: got wr=%b src=%0d want 1/0", fifo_wr, fifo_src); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0100;
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_src !== 3'd2) begin errors++; $display("FAIL mrst_w1: got wr=%b src=%0d want 1/2", fifo_wr, fifo_src); end
    accept();
    tick();
    drive_data();
    srst = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== word(2, 1)) begin errors++; $display("FAIL mrst_w2: got wr=%b data=%h want 1/%h", fifo_wr, fifo_data, word(2, 1)); end
    accept();
    tick();
    drive_data();
    srst = 1'b0;
    req_valid = 4'b0110;
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_after: got wr=%b busy=%b want 0/0", fifo_wr, busy); end
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_src !== 3'd1) begin errors++; $display("FAIL mrst_next: got wr=%b src=%0d want 1/1", fifo_wr, fifo_src); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random_fifo();
    logic [31:0] fq[$];
    logic [31:0] d;
    int pop_cnt[N];
    int src, s, total;
    bit pop;
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      fifo_full = (fq.size() >= 4);
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
      pop = ($urandom_range(0, 2) == 0);
      #1;
      if (fifo_wr) begin
        src = int'(fifo_src);
        checks++; if (fifo_full) begin errors++; $display("FAIL rnd_wr_full cyc%0d: wr=1 while full", cyc); end
        checks++;
        if (src >= N || fifo_data !== word(src, seq[src])) begin
          errors++; $display("FAIL rnd_order cyc%0d: got %h src=%0d", cyc, fifo_data, src);
        end
        fq.push_back(fifo_data);
      end
      if (pop && fq.size() > 0) begin
        d = fq.pop_front();
        s = int'(d[27:24]);
        checks++;
        if (s >= N || int'(d[23:0]) != pop_cnt[s]) begin
          errors++; $display("FAIL rnd_pop cyc%0d: got %h", cyc, d);
        end else pop_cnt[s]++;
      end
      accept();
      tick();
      drive_data();
    end
    req_valid = '0; fifo_full = 1'b0;
    tick();
    while (fq.size() > 0) begin
      d = fq.pop_front();
      s = int'(d[27:24]);
      checks++;
      if (s >= N || int'(d[23:0]) != pop_cnt[s]) begin
        errors++; $display("FAIL rnd_drain: got %h", d);
      end else pop_cnt[s]++;
    end
    total = 0;
    for (int i = 0; i < N; i++) begin
      total += seq[i];
      checks++;
      if (pop_cnt[i] != seq[i]) begin errors++; $display("FAIL rnd_count req%0d: popped %0d accepted %0d", i, pop_cnt[i], seq[i]); end
    end
    checks++; if (total < 100) begin errors++; $display("FAIL rnd_progress: accepted %0d want >=100", total); end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_reset_mid_burst();
    test_random_fifo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vxe_fifo_wr_arb.md
VXE_FIFO_WR_ARB -- requirements
Module: vxe_fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each requester's data word and of the FIFO write data.
REQ-002 The block SHALL have parameter NREQ, default 4, legal range 2..8: number of requesters.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, legal range 1..16: maximum number of writes per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: bit i set means requester i presents a word.
REQ-007 The block SHALL have port req_data, input, NREQ*DATA_WIDTH bits: requester i's word sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: bit i set means requester i's word is accepted this cycle.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: full flag of the downstream shared FIFO.
REQ-010 The block SHALL have port fifo_wr, output, 1 bit: FIFO write strobe.
REQ-011 The block SHALL have port fifo_data, output, DATA_WIDTH bits: FIFO write data.
REQ-012 The block SHALL have port fifo_src, output, 3 bits: index of the requester sourcing the current write.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a grant is held.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and GRANT, with registered state, grant index gnt, last-served index last and burst counter cnt.
REQ-015 In IDLE with any req_valid bit set, the FSM SHALL load gnt with the first set bit searching cyclically from last+1 (mod NREQ), clear cnt and enter GRANT next cycle.
REQ-016 In IDLE with no req_valid bit set, the FSM SHALL remain in IDLE.
REQ-017 In IDLE, req_ready, fifo_wr and busy SHALL be 0; first write SHALL therefore occur 1 cycle after req_valid rises.
REQ-018 In GRANT, req_ready[gnt] SHALL equal !fifo_full, combinationally, and all other req_ready bits SHALL be 0.
REQ-019 fifo_wr SHALL equal req_valid[gnt] & req_ready[gnt]; fifo_data SHALL equal requester gnt's data; fifo_src SHALL equal gnt (zero-extended); all three are combinational.
REQ-020 busy SHALL be 1 exactly in GRANT.
REQ-021 Each cycle with fifo_wr=1, cnt SHALL increment by 1.
REQ-022 GRANT SHALL exit to IDLE, with last<=gnt, on a write where cnt==BURST_LEN-1, i.e. the BURST_LEN-th write of the grant.
REQ-023 GRANT SHALL exit to IDLE, with last<=gnt, in any cycle where req_valid[gnt]=0 (requester dropped); no write occurs that cycle.
REQ-024 If fifo_full=1 and req_valid[gnt]=1, GRANT SHALL hold: no write, cnt unchanged, no timeout.
REQ-025 A requester SHALL NOT be granted twice in succession while another requester has valid asserted at the IDLE decision cycle.
REQ-026 Wrap-around: search from last=NREQ-1 SHALL begin at index 0.
REQ-027 Changes of req_valid bits other than gnt during GRANT SHALL have no effect until the next IDLE decision.

Reset
REQ-028 srst=1 SHALL force, on the next rising edge, state=IDLE, gnt=0, cnt=0 and last=NREQ-1, so that requester 0 has top priority after reset.
REQ-029 srst SHALL take precedence over all other inputs, including mid-burst; words not yet written are not written, and no write SHALL be issued in the cycle after srst is sampled.
REQ-030 After reset, outputs SHALL be: req_ready=0, fifo_wr=0, busy=0, fifo_src=0, and fifo_data = requester 0's data.

Verification
REQ-031 Bench SHALL cover: NREQ=4, BURST_LEN=4; only req 2 valid with data 0xBEEF_0001..0005 -> IDLE cycle, then 4 writes with fifo_src=2, then IDLE, then 1 write of 0xBEEF_0005.
REQ-032 Bench SHALL cover: all 4 requesters continuously valid after reset -> grant order 0,1,2,3,0, with 4 writes each and one idle cycle between grants.
REQ-033 Bench SHALL cover: req 1 granted, fifo_full=1 for 3 cycles after its 2nd write -> fifo_wr=0 and req_ready=0 for those 3 cycles, then writes 3 and 4 follow, and cnt stays unchanged while stalled.
REQ-034 Bench SHALL cover: req 3 granted, drops valid after 1 write -> exit to IDLE, and a valid req 0 is granted next (wrap from last=3).
REQ-035 Bench SHALL cover: srst pulsed after 2nd write of req 2 -> no further fifo_wr, busy=0 next cycle, and with reqs 2 and 1 valid, req 1 is granted next.
REQ-036 Bench SHALL cover: reference model with vxe_fifo_2 (DEPTH_POW2=2) downstream under random valid/full -> every accepted word appears in the FIFO exactly once, in acceptance order, and fifo_wr is never asserted while full.
